// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//   Shares one multi-cycle divider among N_REQ requesting PEs. A round-robin
//   search picks one pending request, the operands are latched and issued to
//   the divider as a single-cycle pulse, and the returned quotient/remainder
//   is handed back to the issuing requester through a valid/ready response.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               abort the in-flight request
//   req_valid_i/ready_o   per-requester request handshake (ready is one-hot)
//   req_a_i, req_b_i      packed operands, requester k at [k*N_BITS +: N_BITS]
//   div_a_o, div_b_o      latched operands to the divider
//   div_in_valid_o        issue pulse to the divider
//   div_q_i, div_r_i      divider result, qualified by div_valid_i
//   rsp_valid_o/ready_i   per-requester response handshake (valid is one-hot)
//   rsp_q_o, rsp_r_o      broadcast result registers
//   busy_cycles_o         saturating count of cycles spent outside IDLE
//   err_spurious_o        sticky flag: divider result arrived unexpectedly
module div_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int N_BITS = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*N_BITS-1:0]   req_a_i,
    input  logic [N_REQ*N_BITS-1:0]   req_b_i,
    output logic [N_BITS-1:0]         div_a_o,
    output logic [N_BITS-1:0]         div_b_o,
    output logic                      div_in_valid_o,
    input  logic [N_BITS-1:0]         div_q_i,
    input  logic [N_BITS-1:0]         div_r_i,
    input  logic                      div_valid_i,
    output logic [N_REQ-1:0]          rsp_valid_o,
    input  logic [N_REQ-1:0]          rsp_ready_i,
    output logic [N_BITS-1:0]         rsp_q_o,
    output logic [N_BITS-1:0]         rsp_r_o,
    output logic [31:0]               busy_cycles_o,
    output logic                      err_spurious_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     tag;
    logic [N_BITS-1:0] op_a;
    logic [N_BITS-1:0] op_b;
    logic [N_BITS-1:0] res_q;
    logic [N_BITS-1:0] res_r;
    logic [31:0]       busy_cnt;
    logic              err_flag;

    logic              found;
    logic [PW-1:0]     winner;
    logic              grant;
    int                idx;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    // A flush in IDLE suppresses the grant for that cycle.
    assign grant       = (state == IDLE) && found && !flush_i;
    assign req_ready_o = grant ? (N_REQ'(1) << winner) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tag      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            res_r    <= '0;
            busy_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state != IDLE && busy_cnt != 32'hFFFF_FFFF)
                busy_cnt <= busy_cnt + 32'd1;

            if (div_valid_i && (state == IDLE || state == ISSUE || state == RESP))
                err_flag <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant) begin
                        op_a   <= req_a_i[int'(winner)*N_BITS +: N_BITS];
                        op_b   <= req_b_i[int'(winner)*N_BITS +: N_BITS];
                        tag    <= winner;
                        rr_ptr <= (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
                        state  <= ISSUE;
                    end
                end
                // The issue pulse goes out even when flushed so the divider
                // always sees a complete transaction; its result is drained.
                ISSUE: state <= flush_i ? DRAIN : WAIT;
                WAIT: begin
                    if (div_valid_i && flush_i) begin
                        state <= IDLE;
                    end else if (div_valid_i) begin
                        res_q <= div_q_i;
                        res_r <= div_r_i;
                        state <= RESP;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                RESP: begin
                    if (flush_i || rsp_ready_i[tag])
                        state <= IDLE;
                end
                DRAIN: begin
                    if (div_valid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_a_o        = op_a;
    assign div_b_o        = op_b;
    assign div_in_valid_o = (state == ISSUE);
    assign rsp_valid_o    = (state == RESP) ? (N_REQ'(1) << tag) : '0;
    assign rsp_q_o        = res_q;
    assign rsp_r_o        = res_r;
    assign busy_cycles_o  = busy_cnt;
    assign err_spurious_o = err_flag;

endmodule
